// File: rtl/multicycle_sequencer_pkg.sv
// Shared constants for the multi-cycle stage sequencer.
`timescale 1ns/1ps
package multicycle_sequencer_pkg;

  // Sequencer FSM encodings
  typedef enum logic [1:0] {
    SEQ_STATE_HOLD   = 2'd0,
    SEQ_STATE_RUN    = 2'd1,
    SEQ_STATE_HALTED = 2'd2
  } seq_state_e;

  // Default stage count: fetch, decode, execute, memory, writeback
  localparam int SEQ_DEFAULT_NUM_STAGES = 5;

endpackage

// File: rtl/stage_counter.sv
// Modulo-NUM_STAGES stage index counter with enable and synchronous clear.
`timescale 1ns/1ps
module stage_counter #(
  parameter int NUM_STAGES = 5,
  parameter int CW         = $clog2(NUM_STAGES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cur_stage
);

  localparam logic [CW-1:0] LAST = CW'(NUM_STAGES - 1);

  logic [CW-1:0] cur_q;
  logic [CW-1:0] cur_d;

  // Clear has priority; advancing past the last stage wraps to fetch
  always_comb begin
    cur_d = cur_q;
    if (clr) begin
      cur_d = '0;
    end else if (en) begin
      cur_d = (cur_q == LAST) ? '0 : cur_q + CW'(1);
    end
  end

  // Stage index register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign cur_stage = cur_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Stage sequencer for the multi-cycle core: one active stage at a time,
// per-stage wait states, flush, run/halt/single-step and retired counter.
//
//   state            | meaning
//   -----------------+----------------------------------------------------
//   SEQ_STATE_HOLD   | post-reset hold, pipeline registers held in reset
//   SEQ_STATE_RUN    | stepping through stages, one stage_en per ready stage
//   SEQ_STATE_HALTED | idle at an instruction boundary, waiting for run/step
`timescale 1ns/1ps
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = SEQ_DEFAULT_NUM_STAGES,
  parameter int CNT_WIDTH  = 32,
  parameter int RESET_HOLD = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic                          step,
  input  logic                          flush,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  output logic [NUM_STAGES-1:0]         stage_en,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  output logic                          stage_reset_n,
  output logic                          commit,
  output logic                          halted,
  output logic [CNT_WIDTH-1:0]          retired_count
);

  localparam int CW = $clog2(NUM_STAGES);
  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CW-1:0] LAST_STAGE = CW'(NUM_STAGES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_HOLD - 1);
  localparam logic [NUM_STAGES-1:0] ONE_HOT0 = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  seq_state_e           state_q, state_d;
  logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
  logic                 step_pending_q, step_pending_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic [CW-1:0] cur;
  logic          active;
  logic          advance;
  logic          on_last;

  assign active  = (state_q == SEQ_STATE_RUN);
  assign advance = active & stage_ready[cur] & ~flush;
  assign on_last = (cur == LAST_STAGE);

  // Flush only restarts the instruction while running; in HALTED cur is already 0
  stage_counter #(
    .NUM_STAGES (NUM_STAGES),
    .CW         (CW)
  ) u_stage_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (advance),
    .clr       (active & flush),
    .cur_stage (cur)
  );

  // One-hot write-enable decode for the active stage
  always_comb begin
    stage_en = '0;
    if (advance) begin
      stage_en = ONE_HOT0 << cur;
    end
  end

  assign commit        = advance & on_last;
  assign cur_stage     = cur;
  assign halted        = (state_q == SEQ_STATE_HALTED);
  assign stage_reset_n = (state_q != SEQ_STATE_HOLD);
  assign retired_count = retired_q;

  // Next-state, hold timer, step latch and retirement count
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    step_pending_d = step_pending_q;
    retired_d      = retired_q;
    unique case (state_q)
      SEQ_STATE_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = run ? SEQ_STATE_RUN : SEQ_STATE_HALTED;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      SEQ_STATE_RUN: begin
        if (commit) begin
          retired_d = retired_q + CNT_WIDTH'(1);
          if (!run || step_pending_q) begin
            state_d        = SEQ_STATE_HALTED;
            step_pending_d = 1'b0;
          end
        end
      end
      SEQ_STATE_HALTED: begin
        if (run) begin
          state_d = SEQ_STATE_RUN;
        end else if (step) begin
          state_d        = SEQ_STATE_RUN;
          step_pending_d = 1'b1;
        end
      end
      default: state_d = SEQ_STATE_HOLD;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= SEQ_STATE_HOLD;
      hold_cnt_q     <= '0;
      step_pending_q <= 1'b0;
      retired_q      <= '0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      step_pending_q <= step_pending_d;
      retired_q      <= retired_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-cycle expectations from a small model
// are queued when inputs are driven and compared mid-cycle by a monitor.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          flush = 1'b0;
  logic [NS-1:0] stage_ready = '0;
  logic [NS-1:0] stage_en;
  logic [2:0]    cur_stage;
  logic          stage_reset_n;
  logic          commit;
  logic          halted;
  logic [3:0]    retired_count;

  multicycle_sequencer #(
    .NUM_STAGES (NS),
    .CNT_WIDTH  (4),
    .RESET_HOLD (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .step          (step),
    .flush         (flush),
    .stage_ready   (stage_ready),
    .stage_en      (stage_en),
    .cur_stage     (cur_stage),
    .stage_reset_n (stage_reset_n),
    .commit        (commit),
    .halted        (halted),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] en;
    logic          cmt;
    logic [2:0]    cur;
    logic          hlt;
    logic          srn;
    logic [3:0]    ret;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: 0 = hold, 1 = run, 2 = halted
  int         m_state;
  int         m_hold_left;
  int         m_cur;
  logic       m_pend;
  logic [3:0] m_ret;

  task automatic model_reset();
    m_state = 0; m_hold_left = 2; m_cur = 0; m_pend = 1'b0; m_ret = 4'd0;
  endtask

  task automatic model_push(input logic f, input logic [NS-1:0] rdy);
    exp_t e;
    e.en  = '0;
    if (m_state == 1 && !f && rdy[m_cur]) e.en[m_cur] = 1'b1;
    e.cmt = e.en[NS-1];
    e.cur = 3'(m_cur);
    e.hlt = (m_state == 2);
    e.srn = (m_state != 0);
    e.ret = m_ret;
    sb.push_back(e);
  endtask

  task automatic model_step(input logic r, input logic s, input logic f, input logic [NS-1:0] rdy);
    case (m_state)
      0: begin
        m_hold_left--;
        if (m_hold_left == 0) m_state = r ? 1 : 2;
      end
      1: begin
        if (f) m_cur = 0;
        else if (rdy[m_cur]) begin
          if (m_cur == NS - 1) begin
            m_cur = 0;
            m_ret = m_ret + 4'd1;
            if (!r || m_pend) begin m_state = 2; m_pend = 1'b0; end
          end else m_cur++;
        end
      end
      default: begin
        if (r) m_state = 1;
        else if (s) begin m_state = 1; m_pend = 1'b1; end
      end
    endcase
  endtask

  task automatic tick(input logic r, input logic s, input logic f, input logic [NS-1:0] rdy);
    run = r; step = s; flush = f; stage_ready = rdy;
    model_push(f, rdy);
    @(posedge clk);
    model_step(r, s, f, rdy);
    #1;
  endtask

  // Monitor: compare queued expectation mid-cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val("stage_en", 32'(stage_en), 32'(e.en));
      check_val("commit", 32'(commit), 32'(e.cmt));
      check_val("cur_stage", 32'(cur_stage), 32'(e.cur));
      check_val("halted", 32'(halted), 32'(e.hlt));
      check_val("stage_reset_n", 32'(stage_reset_n), 32'(e.srn));
      check_val("retired", 32'(retired_count), 32'(e.ret));
    end
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_en"}, 32'(stage_en), 0);
    check_val({tag, "_commit"}, 32'(commit), 0);
    check_val({tag, "_cur"}, 32'(cur_stage), 0);
    check_val({tag, "_halted"}, 32'(halted), 0);
    check_val({tag, "_srn"}, 32'(stage_reset_n), 0);
    check_val({tag, "_ret"}, 32'(retired_count), 0);
  endtask

  localparam logic [NS-1:0] ALL = 5'b11111;

  initial begin
    model_reset();
    run = 1'b1; stage_ready = ALL;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;

    // Hold for two edges, then free-run two instructions
    tick(1, 0, 0, ALL);
    check_val("hold_srn_low", 32'(stage_reset_n), 0);
    tick(1, 0, 0, ALL);
    check_val("hold_srn_high", 32'(stage_reset_n), 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, ALL);
    check_val("ret_after_5", 32'(retired_count), 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, ALL);
    check_val("ret_after_10", 32'(retired_count), 2);

    // Three wait states on stage 3
    for (int i = 0; i < 3; i++) tick(1, 0, 0, ALL);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 5'b10111);
    check_val("wait_cur3", 32'(cur_stage), 3);
    tick(1, 0, 0, ALL);
    check_val("wait_cur4", 32'(cur_stage), 4);
    tick(1, 0, 0, ALL);
    check_val("wait_ret", 32'(retired_count), 3);

    // Flush at stage 2, then at the last stage together with ready
    tick(1, 0, 0, ALL);
    tick(1, 0, 0, ALL);
    tick(1, 0, 1, ALL);
    check_val("flush2_cur", 32'(cur_stage), 0);
    check_val("flush2_ret", 32'(retired_count), 3);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, ALL);
    tick(1, 0, 1, ALL);
    check_val("flush4_cur", 32'(cur_stage), 0);
    check_val("flush4_ret", 32'(retired_count), 3);

    // Drop run at stage 1: instruction finishes, then halts
    tick(1, 0, 0, ALL);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, ALL);
    check_val("halt_flag", 32'(halted), 1);
    check_val("halt_ret", 32'(retired_count), 4);
    for (int i = 0; i < 10; i++) tick(0, 0, (i % 3) == 0, ALL);
    check_val("idle_cur", 32'(cur_stage), 0);

    // Single step executes exactly one instruction
    tick(0, 1, 0, ALL);
    check_val("step_running", 32'(halted), 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, ALL);
    check_val("step_halted", 32'(halted), 1);
    check_val("step_ret", 32'(retired_count), 5);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, ALL);

    // run and step together: run wins, no halt after the instruction
    tick(1, 1, 0, ALL);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, ALL);
    check_val("runstep_halted", 32'(halted), 0);
    check_val("runstep_ret", 32'(retired_count), 6);

    // Counter wrap 15 -> 0
    for (int i = 0; i < 45; i++) tick(1, 0, 0, ALL);
    check_val("ret_15", 32'(retired_count), 15);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, ALL);
    check_val("ret_wrap", 32'(retired_count), 0);

    // Asynchronous reset at stage 3 with stage 3 ready
    for (int i = 0; i < 3; i++) tick(1, 0, 0, ALL);
    check_val("pre_rst_cur", 32'(cur_stage), 3);
    #1 reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(1, 0, 0, ALL);
    check_val("rehold_srn_low", 32'(stage_reset_n), 0);
    tick(1, 0, 0, ALL);
    check_val("rehold_srn_high", 32'(stage_reset_n), 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, ALL);
    check_val("rehold_ret", 32'(retired_count), 1);

    @(negedge clk);
    check_val("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
